key_event_gen: RTL and testbench

- Consumer side of the debounced key path: takes one clean key level from the key debouncer and turns it into single-cycle events for the clock-setting logic.
- Events: press edge, release edge, short press, long press, and auto-repeat while the key is held.
- One instance per key. Outputs are registered and drive the time-set FSM / counter increment enables directly.

---
 rtl/key_event_gen_if.sv | 21 ++
 rtl/key_event_gen.sv | 127 ++++++++++++
 tb/tb_key_event_gen.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/key_event_gen_if.sv
// Key level in, single-cycle key events out, for one debounced key.
// Modport slave is the event generator; master is whoever drives the key and consumes events.
interface key_event_gen_if;
    logic KeyLevel;
    logic PressPulse;
    logic ReleasePulse;
    logic ShortPress;
    logic LongPress;
    logic RepeatPulse;
    logic Held;

    modport master (
        output KeyLevel,
        input  PressPulse, ReleasePulse, ShortPress, LongPress, RepeatPulse, Held
    );

    modport slave (
        input  KeyLevel,
        output PressPulse, ReleasePulse, ShortPress, LongPress, RepeatPulse, Held
    );
endinterface

// File: rtl/key_event_gen.sv
// Turns a debounced key level into press/release/short/long/repeat pulses plus a held level.
// Latency: every event is registered, 1 clk after the sampled key condition.
// Backpressure: none; events are fire-and-forget pulses.
module key_event_gen #(
    parameter bit          ACTIVE_LOW = 1'b1,
    parameter logic [31:0] LONG_CNT   = 32'd50000000,
    parameter logic [31:0] REPEAT_CNT = 32'd10000000
) (
    input  logic            clk,
    input  logic            rst,
    key_event_gen_if.slave  key_if
);

    typedef enum logic [1:0] {WAIT_REL, IDLE, PRESSED, LONG} state_t;

    localparam logic PRESS_LVL = ACTIVE_LOW ? 1'b0 : 1'b1;

    state_t      state_q, state_d;
    logic [31:0] hc_q, hc_d;
    logic [31:0] rc_q, rc_d;
    logic        p_q, p;
    logic        press_q, press_d;
    logic        release_q, release_d;
    logic        short_q, short_d;
    logic        long_q, long_d;
    logic        repeat_q, repeat_d;
    logic        held_q, held_d;

    assign p = (key_if.KeyLevel == PRESS_LVL);

    always_comb begin
        state_d   = state_q;
        hc_d      = hc_q;
        rc_d      = rc_q;
        held_d    = held_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            // A key still held from reset must be released before it can count.
            WAIT_REL: begin
                if (!p) begin
                    state_d = IDLE;
                    hc_d    = '0;
                    rc_d    = '0;
                end
            end
            IDLE: begin
                if (p && !p_q) begin
                    state_d = PRESSED;
                    hc_d    = '0;
                    rc_d    = '0;
                    press_d = 1'b1;
                    held_d  = 1'b1;
                end
            end
            PRESSED: begin
                if (!p) begin
                    state_d   = IDLE;
                    hc_d      = '0;
                    rc_d      = '0;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    held_d    = 1'b0;
                end else if (hc_q == LONG_CNT - 32'd1) begin
                    state_d = LONG;
                    hc_d    = '0;
                    rc_d    = '0;
                    long_d  = 1'b1;
                end else begin
                    hc_d = hc_q + 32'd1;
                end
            end
            LONG: begin
                if (!p) begin
                    state_d   = IDLE;
                    hc_d      = '0;
                    rc_d      = '0;
                    release_d = 1'b1;
                    held_d    = 1'b0;
                end else if (rc_q == REPEAT_CNT - 32'd1) begin
                    rc_d     = '0;
                    repeat_d = 1'b1;
                end else begin
                    rc_d = rc_q + 32'd1;
                end
            end
            default: state_d = WAIT_REL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= WAIT_REL;
            hc_q      <= '0;
            rc_q      <= '0;
            p_q       <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hc_q      <= hc_d;
            rc_q      <= rc_d;
            p_q       <= p;
            press_q   <= press_d;
            release_q <= release_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign key_if.PressPulse   = press_q;
    assign key_if.ReleasePulse = release_q;
    assign key_if.ShortPress   = short_q;
    assign key_if.LongPress    = long_q;
    assign key_if.RepeatPulse  = repeat_q;
    assign key_if.Held         = held_q;

endmodule

// File: tb/tb_key_event_gen.sv
// Two instances (active-low/repeat 4 and active-high/repeat 1) share one logical key,
// checked every cycle against a press-length model, with a few literal pins on the model.
module tb_key_event_gen;

    localparam int LC [2] = '{10, 10};
    localparam int RP [2] = '{4, 1};

    logic clk;
    logic rst;
    logic press;

    key_event_gen_if if_a ();
    key_event_gen_if if_b ();

    assign if_a.KeyLevel = ~press;
    assign if_b.KeyLevel = press;

    key_event_gen #(.ACTIVE_LOW(1'b1), .LONG_CNT(32'd10), .REPEAT_CNT(32'd4)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .key_if (if_a)
    );

    key_event_gen #(.ACTIVE_LOW(1'b0), .LONG_CNT(32'd10), .REPEAT_CNT(32'd1)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .key_if (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;

    // Model state: armed = a release has been seen since reset; n = pressed samples so far.
    bit   armed  [2];
    bit   active [2];
    bit   prev_p [2];
    int   n_hold [2];
    logic ex_press [2];
    logic ex_rel   [2];
    logic ex_short [2];
    logic ex_long  [2];
    logic ex_rep   [2];
    logic ex_held  [2];

    task automatic chk(input string nm, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic model_step(input logic r, input logic p);
        for (int i = 0; i < 2; i++) begin
            ex_press[i] = 1'b0;
            ex_rel[i]   = 1'b0;
            ex_short[i] = 1'b0;
            ex_long[i]  = 1'b0;
            ex_rep[i]   = 1'b0;
            if (r) begin
                armed[i]  = 1'b0;
                active[i] = 1'b0;
                prev_p[i] = 1'b0;
                n_hold[i] = 0;
            end else begin
                if (!armed[i]) begin
                    if (!p) armed[i] = 1'b1;
                end else if (!active[i]) begin
                    if (p && !prev_p[i]) begin
                        active[i]   = 1'b1;
                        n_hold[i]   = 1;
                        ex_press[i] = 1'b1;
                    end
                end else if (p) begin
                    n_hold[i]++;
                    ex_long[i] = (n_hold[i] == LC[i] + 1);
                    ex_rep[i]  = (n_hold[i] > LC[i] + 1) && ((n_hold[i] - LC[i] - 1) % RP[i] == 0);
                end else begin
                    ex_rel[i]   = 1'b1;
                    ex_short[i] = (n_hold[i] <= LC[i]);
                    active[i]   = 1'b0;
                end
                prev_p[i] = p;
            end
            ex_held[i] = active[i];
        end
    endtask

    initial begin : model_and_compare
        forever begin
            @(posedge clk);
            cyc++;
            model_step(rst, press);
            @(negedge clk);
            chk("a.PressPulse",   if_a.PressPulse,   ex_press[0]);
            chk("a.ReleasePulse", if_a.ReleasePulse, ex_rel[0]);
            chk("a.ShortPress",   if_a.ShortPress,   ex_short[0]);
            chk("a.LongPress",    if_a.LongPress,    ex_long[0]);
            chk("a.RepeatPulse",  if_a.RepeatPulse,  ex_rep[0]);
            chk("a.Held",         if_a.Held,         ex_held[0]);
            chk("b.PressPulse",   if_b.PressPulse,   ex_press[1]);
            chk("b.ReleasePulse", if_b.ReleasePulse, ex_rel[1]);
            chk("b.ShortPress",   if_b.ShortPress,   ex_short[1]);
            chk("b.LongPress",    if_b.LongPress,    ex_long[1]);
            chk("b.RepeatPulse",  if_b.RepeatPulse,  ex_rep[1]);
            chk("b.Held",         if_b.Held,         ex_held[1]);
        end
    end

    // Inputs are applied right after a falling edge and held across the next rising edge.
    task automatic step(input logic r, input logic p);
        rst   = r;
        press = p;
        @(negedge clk);
    endtask

    task automatic hold(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b1);
    endtask

    task automatic gap(input int cycles);
        for (int k = 0; k < cycles; k++) step(1'b0, 1'b0);
    endtask

    initial begin : stimulus
        rst   = 1'b1;
        press = 1'b0;
        repeat (3) step(1'b1, 1'b0);
        chk("pin_reset_held_a", ex_held[0], 1'b0);
        gap(3);

        // 5-cycle press: short press on release
        step(1'b0, 1'b1);
        chk("pin_t1_press", ex_press[0], 1'b1);
        chk("pin_t1_held",  ex_held[0],  1'b1);
        hold(4);
        step(1'b0, 1'b0);
        chk("pin_t1_release", ex_rel[0],   1'b1);
        chk("pin_t1_short",   ex_short[0], 1'b1);
        gap(3);

        // 25-cycle hold: long at t+11, repeats at t+15/19/23
        step(1'b0, 1'b1);
        hold(9);
        chk("pin_t2_no_long_yet", ex_long[0], 1'b0);
        step(1'b0, 1'b1);
        chk("pin_t2_long", ex_long[0], 1'b1);
        chk("pin_t2_long_no_rep", ex_rep[0], 1'b0);
        hold(3);
        chk("pin_t2_no_rep_early", ex_rep[0], 1'b0);
        step(1'b0, 1'b1);
        chk("pin_t2_rep1", ex_rep[0], 1'b1);
        hold(10);
        step(1'b0, 1'b0);
        chk("pin_t2_release",  ex_rel[0],   1'b1);
        chk("pin_t2_no_short", ex_short[0], 1'b0);
        gap(3);

        // exactly 10 cycles: release wins over long
        hold(10);
        step(1'b0, 1'b0);
        chk("pin_t3_short", ex_short[0], 1'b1);
        chk("pin_t3_nolong", ex_long[0], 1'b0);
        gap(2);

        // key held through reset
        repeat (3) step(1'b1, 1'b1);
        hold(20);
        chk("pin_t4_no_held", ex_held[0], 1'b0);
        gap(2);
        step(1'b0, 1'b1);
        chk("pin_t4_press", ex_press[0], 1'b1);

        // reset while in LONG with rc=2
        hold(12);
        step(1'b1, 1'b1);
        chk("pin_t5_rst_rep", ex_rep[0],  1'b0);
        chk("pin_t5_rst_held", ex_held[0], 1'b0);
        hold(5);
        gap(2);

        // 14-cycle hold on the repeat-every-cycle instance
        step(1'b0, 1'b1);
        hold(9);
        step(1'b0, 1'b1);
        chk("pin_t6_long_b", ex_long[1], 1'b1);
        step(1'b0, 1'b1);
        chk("pin_t6_rep_b", ex_rep[1], 1'b1);
        hold(2);
        step(1'b0, 1'b0);
        chk("pin_t6_rel_b", ex_rel[1], 1'b1);
        chk("pin_t6_rel_norep_b", ex_rep[1], 1'b0);
        gap(2);

        // random presses, gaps, occasional reset
        repeat (150) begin
            int g;
            int h;
            g = $urandom_range(1, 6);
            h = $urandom_range(1, 30);
            for (int k = 0; k < g; k++) step(($urandom_range(0, 60) == 0), 1'b0);
            for (int k = 0; k < h; k++) step(($urandom_range(0, 60) == 0), 1'b1);
        end
        gap(4);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
